// File: rtl/cpu_pkg.sv
// Shared types for the CPU pipeline controller: FSM state encoding,
// the per-cycle control bundle and the default stall-counter width.
package cpu_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifd_en;
        logic pipe_en;
        logic dec_bubble;
        logic if_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_RUN  = '{pc_en: 1'b1, ifd_en: 1'b1, pipe_en: 1'b1,
                                         dec_bubble: 1'b0, if_flush: 1'b0};
    localparam pipe_ctrl_t PIPE_IDLE = '{pc_en: 1'b0, ifd_en: 1'b0, pipe_en: 1'b0,
                                         dec_bubble: 1'b0, if_flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import cpu_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline stall/flush/halt controller for a five-stage core, with a
// saturating count of cycles in which the PC was held.
module cpu_pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rw_stall,
    input  logic             jb_stall,
    input  logic             br_taken,
    input  logic             mem_busy,
    input  logic             halt,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ifd_en,
    output logic             pipe_en,
    output logic             dec_bubble,
    output logic             if_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t state_q;
    pipe_state_t state_d;
    pipe_ctrl_t  ctrl;
    logic        cnt_inc;

    // State and halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == HALT);
        end
    end

    // Request resolution: halt > mem_busy > br_taken > jb_stall > rw_stall
    always_comb begin
        ctrl    = PIPE_RUN;
        state_d = state_q;
        if ((state_q == HALT) || halt) begin
            ctrl    = PIPE_IDLE;
            state_d = HALT;
        end else if (mem_busy) begin
            ctrl = PIPE_IDLE;
        end else begin
            if (br_taken) begin
                ctrl.if_flush = 1'b1;
                state_d       = FLUSH;
            end else if (jb_stall || rw_stall) begin
                ctrl.pc_en      = 1'b0;
                ctrl.ifd_en     = 1'b0;
                ctrl.dec_bubble = 1'b1;
                state_d         = STALL;
            end else begin
                state_d = RUN;
            end
            // One bubble squashes the wrong-path instruction now sitting in DEC
            if (state_q == FLUSH) begin
                ctrl.dec_bubble = 1'b1;
            end
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifd_en     = ctrl.ifd_en;
    assign pipe_en    = ctrl.pipe_en;
    assign dec_bubble = ctrl.dec_bubble;
    assign if_flush   = ctrl.if_flush;

    assign cnt_inc = !ctrl.pc_en && (state_d != HALT);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed self-checking bench for cpu_pipe_ctrl (default and 4-bit counter builds).
module tb_cpu_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rw_stall, jb_stall, br_taken, mem_busy, halt, cnt_clr;
    logic        pc_en, ifd_en, pipe_en, dec_bubble, if_flush, halted;
    logic [15:0] stall_cnt;
    logic        pc_en4, ifd_en4, pipe_en4, dec_bubble4, if_flush4, halted4;
    logic [3:0]  stall_cnt4;
    logic [5:0]  outv;
    logic [5:0]  outv4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outv  = {pc_en, ifd_en, pipe_en, dec_bubble, if_flush, halted};
    assign outv4 = {pc_en4, ifd_en4, pipe_en4, dec_bubble4, if_flush4, halted4};

    cpu_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rw_stall(rw_stall), .jb_stall(jb_stall),
        .br_taken(br_taken), .mem_busy(mem_busy), .halt(halt), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .ifd_en(ifd_en), .pipe_en(pipe_en), .dec_bubble(dec_bubble),
        .if_flush(if_flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    cpu_pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rw_stall(rw_stall), .jb_stall(jb_stall),
        .br_taken(br_taken), .mem_busy(mem_busy), .halt(halt), .cnt_clr(cnt_clr),
        .pc_en(pc_en4), .ifd_en(ifd_en4), .pipe_en(pipe_en4), .dec_bubble(dec_bubble4),
        .if_flush(if_flush4), .halted(halted4), .stall_cnt(stall_cnt4)
    );

    // Apply one cycle of inputs at the falling edge, then settle before sampling.
    task automatic set_in(input logic rw, input logic jb, input logic br,
                          input logic mb, input logic ht, input logic clr);
        @(negedge clk);
        rw_stall = rw; jb_stall = jb; br_taken = br;
        mem_busy = mb; halt = ht; cnt_clr = clr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rw_stall = 1'b0; jb_stall = 1'b0; br_taken = 1'b0;
        mem_busy = 1'b0; halt = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // outv = {pc_en, ifd_en, pipe_en, dec_bubble, if_flush, halted}
    task automatic test_reset();
        rst_n = 1'b0;
        rw_stall = 1'b0; jb_stall = 1'b0; br_taken = 1'b0;
        mem_busy = 1'b0; halt = 1'b0; cnt_clr = 1'b0;
        #12;
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL reset_out got %b exp %b", outv, 6'b111000); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL run_idle got %b exp %b", outv, 6'b111000); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL run_idle_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_rw_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            checks++; if (outv !== 6'b001100) begin errors++; $display("FAIL rw_stall[%0d] got %b exp %b", i, outv, 6'b001100); end
        end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL rw_resume got %b exp %b", outv, 6'b111000); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL rw_cnt got %0d exp 3", stall_cnt); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 0, 0, 0);
            checks++; if (outv !== 6'b001100) begin errors++; $display("FAIL jb_stall[%0d] got %b exp %b", i, outv, 6'b001100); end
        end
        set_in(0, 1, 1, 0, 0, 0);
        checks++; if (outv !== 6'b111010) begin errors++; $display("FAIL br_flush got %b exp %b", outv, 6'b111010); end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111100) begin errors++; $display("FAIL flush_bubble got %b exp %b", outv, 6'b111100); end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL flush_run got %b exp %b", outv, 6'b111000); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL br_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_mem_busy();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 1, 0, 0);
            checks++; if (outv !== 6'b000000) begin errors++; $display("FAIL mem_freeze[%0d] got %b exp %b", i, outv, 6'b000000); end
        end
        set_in(1, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL mem_cnt got %0d exp 4", stall_cnt); end
        checks++; if (outv !== 6'b001100) begin errors++; $display("FAIL mem_then_stall got %b exp %b", outv, 6'b001100); end
        set_in(0, 0, 1, 1, 0, 0);
        checks++; if (outv !== 6'b000000) begin errors++; $display("FAIL mem_over_br got %b exp %b", outv, 6'b000000); end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL mem_resume got %b exp %b", outv, 6'b111000); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL mem_cnt2 got %0d exp 6", stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) set_in(1, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 1);
        checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat4 got %0d exp 15", stall_cnt4); end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat16 got %0d exp 20", stall_cnt); end
        set_in(1, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt4 !== 4'd0) begin errors++; $display("FAIL clr4 got %0d exp 0", stall_cnt4); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL clr16 got %0d exp 0", stall_cnt); end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt4 !== 4'd1) begin errors++; $display("FAIL inc_after_clr got %0d exp 1", stall_cnt4); end
        checks++; if (outv4 !== 6'b111000) begin errors++; $display("FAIL dut4_resume got %b exp %b", outv4, 6'b111000); end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 1, 0);
        checks++; if (outv !== 6'b000000) begin errors++; $display("FAIL halt_req got %b exp %b", outv, 6'b000000); end
        for (int i = 0; i < 5; i++) begin
            set_in(1'(i), 1'(i >> 1), 1'(i == 2), 1'(i == 3), 1'b0, 1'b0);
            checks++; if (outv !== 6'b000001) begin errors++; $display("FAIL halted[%0d] got %b exp %b", i, outv, 6'b000001); end
        end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL halt_cnt got %0d exp 2", stall_cnt); end
        set_in(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL halt_rst_out got %b exp %b", outv, 6'b111000); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL halt_rst_cnt got %0d exp 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL halt_exit got %b exp %b", outv, 6'b111000); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        set_in(0, 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111100) begin errors++; $display("FAIL pre_rst_flush got %b exp %b", outv, 6'b111100); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL rst_in_flush got %b exp %b", outv, 6'b111000); end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (outv !== 6'b111000) begin errors++; $display("FAIL no_pending_flush got %b exp %b", outv, 6'b111000); end
    endtask

    initial begin
        test_reset();
        test_rw_stall();
        test_branch_flush();
        test_mem_busy();
        test_saturate();
        test_halt();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_pipe_ctrl.md
CPU_PIPE_CTRL -- requirements
Module: cpu_pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rw_stall  in  1  read-after-write hazard request from the stall detector.
REQ-005 jb_stall  in  1  jump/branch-in-flight request from the stall detector.
REQ-006 br_taken  in  1  one-cycle pulse from execute: branch/jump resolved taken.
REQ-007 mem_busy  in  1  memory stage cannot complete this cycle; whole pipe freezes.
REQ-008 halt  in  1  halt instruction reached writeback.
REQ-009 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-010 pc_en  out  1  PC register update enable.
REQ-011 ifd_en  out  1  IF/DEC pipeline register enable.
REQ-012 pipe_en  out  1  DEC/EXEC, EXEC/MEM and MEM/WB register enable.
REQ-013 dec_bubble  out  1  load NOP into DEC/EXEC instead of the decoded instruction.
REQ-014 if_flush  out  1  replace the IF/DEC contents with NOP.
REQ-015 halted  out  1  core stopped.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 while not halted.

Function
REQ-017 The FSM SHALL have the states RUN, STALL, FLUSH and HALT, encoded in the shared package.
REQ-018 Requests SHALL be resolved each cycle in strict priority order: halt > mem_busy > br_taken > jb_stall > rw_stall.
REQ-019 In HALT, pc_en, ifd_en, pipe_en, dec_bubble and if_flush SHALL all be 0, and halted SHALL be 1.
REQ-020 halt=1 in any state SHALL move the FSM to HALT on the next edge, and HALT SHALL be exited only by rst_n.
REQ-021 When mem_busy=1 and the FSM is not in HALT, all enables SHALL be 0 with dec_bubble=0 and if_flush=0 (full freeze), and the state SHALL hold.
REQ-022 When br_taken=1 (no higher-priority request): pc_en=1, ifd_en=1, pipe_en=1 and if_flush=1 in the same cycle; the next state is FLUSH.
REQ-023 In FLUSH, with no higher-priority request, the outputs SHALL be those of RUN, dec_bubble SHALL be 1 for this single cycle (squashing the wrong-path instruction in DEC), and the next state is RUN.
REQ-024 When jb_stall=1 or rw_stall=1 (no higher-priority request): pc_en=0, ifd_en=0, pipe_en=1, dec_bubble=1; the next state is STALL.
REQ-025 In STALL with both stall requests low, the outputs SHALL equal RUN and the next state SHALL be RUN; the FSM adds no extra latency.
REQ-026 In RUN with no request: pc_en=ifd_en=pipe_en=1, dec_bubble=0, if_flush=0.
REQ-027 All outputs except stall_cnt and halted SHALL be combinational functions of the state and the current inputs; the request-to-enable latency is 0 cycles.
REQ-028 br_taken coinciding with jb_stall SHALL perform the flush; the jb_stall is ignored that cycle.
REQ-029 stall_cnt SHALL increment by 1 on each edge where pc_en=0 and the next state is not HALT.
REQ-030 stall_cnt SHALL saturate at all-ones (2^CNT_W - 1) and not wrap.
REQ-031 cnt_clr=1 SHALL load 0 into stall_cnt, overriding any increment in the same cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force state=RUN, stall_cnt=0 and halted=0.
REQ-033 During reset, the outputs SHALL read pc_en=ifd_en=pipe_en=1, dec_bubble=0 and if_flush=0, subject to the combinational input terms.
REQ-034 Reset asserted mid-STALL, FLUSH or HALT SHALL take effect immediately, and no flush SHALL be pending afterwards.

Structure
REQ-035 Package cpu_pkg SHALL hold the pipe_state_t enum (RUN, STALL, FLUSH, HALT) and the CNT_W default constant.
REQ-036 The saturating counter SHALL be one sub-module, sat_counter, with inputs clk, rst_n, inc and clr.
REQ-037 The block SHALL contain no other sub-modules or memories.

Verification
REQ-038 After reset with all inputs 0 -> pc_en=ifd_en=pipe_en=1, dec_bubble=0, stall_cnt=0.
REQ-039 rw_stall high for 3 cycles -> pc_en=0 and dec_bubble=1 for exactly 3 cycles, RUN outputs resume on the 4th, stall_cnt=3.
REQ-040 jb_stall for 2 cycles then br_taken with jb_stall still high -> if_flush=1 in that cycle, dec_bubble=1 in the next, then RUN; stall_cnt=2.
REQ-041 mem_busy together with rw_stall for 4 cycles -> all enables 0, dec_bubble=0, stall_cnt=4; after mem_busy drops with rw_stall still high -> the stall response applies.
REQ-042 CNT_W=4 with rw_stall held for 20 cycles -> stall_cnt stops at 15; cnt_clr together with rw_stall -> stall_cnt=0 on the next edge.
REQ-043 halt pulse during STALL -> halted=1 and all enables 0 indefinitely, stall_cnt frozen; rst_n low mid-HALT -> immediate RUN with stall_cnt=0.
